// File: rtl/mult16_seq.sv
// -----------------------------------------------------------------------------
// mult16_seq -- sequential unsigned 16x16 -> 32-bit shift-add multiplier.
//
// One partial-product step per clock, built around a single adder16 instance.
// A start accepted in IDLE or DONE launches 16 RUN iterations. The last
// iteration enters DONE and loads the product register. The product register
// holds its value until the next DONE.
//
// Handshake: start is sampled on the rising clk edge and accepted only when
// the FSM is in IDLE or DONE. busy is high for the 16 RUN cycles. done is high
// for the single DONE cycle. Both decode straight from the state flops, so
// start has no combinational path to any output.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   operation request
//   a          in   16  multiplicand, captured on the accepted-start edge
//   b          in   16  multiplier, captured on the accepted-start edge
//   busy       out  1   high while in RUN
//   done       out  1   one-cycle completion pulse
//   product    out  32  registered a*b, held until the next DONE
//   dbg_state  out  2   current FSM state (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------

// adder16 -- 16-bit unsigned adder. o_s is the low 16 bits of the sum and
// o_c is the carry-out (the 17th sum bit).
module adder16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_s,
  output logic        o_c
);
  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module mult16_seq #(
  parameter int WIDTH = 16,  // fixed by the adder16 datapath
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [2*WIDTH-1:0] w_acc_next;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign w_addend = r_acc_lo[0] ? r_mcand : '0;

  adder16 u_adder16 (
    .i_a (r_acc_hi),
    .i_b (w_addend),
    .o_s (w_sum),
    .o_c (w_carry)
  );

  // The 33-bit {carry, sum, acc_lo} shifted right by one. The carry becomes
  // the MSB of acc_hi, so it is never lost.
  assign w_acc_next = {w_carry, w_sum, r_acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_mcand   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_mcand  <= a;
            r_acc_lo <= b;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          {r_acc_hi, r_acc_lo} <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_product <= w_acc_next;
            r_state   <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;  // unused encoding recovers to IDLE
      endcase
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign product   = r_product;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mult16_seq.sv
// -----------------------------------------------------------------------------
// tb_mult16_seq -- directed self-checking bench for mult16_seq.
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mult16_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  mult16_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation with start pulsed for a single edge. The task only
  // measures. Each test compares the returned values itself.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        output int busy_cnt, output int done_cnt,
                        output logic [31:0] prod, output bit timed_out);
    int cyc;
    busy_cnt  = 0;
    done_cnt  = 0;
    prod      = 'x;
    timed_out = 1'b1;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        prod = product;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, product, dbg_state} !== {1'b0, 1'b0, 32'h0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b product=%h state=%0d, want 0/0/0/0",
               busy, done, product, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bc, dc; logic [31:0] p; bit to;
    run_op(16'd3, 16'd5, bc, dc, p, to);
    n_vec++;
    if (to || p !== 32'h0000000F) begin
      n_err++; $display("FAIL basic_3x5: product=%h timeout=%0d, want 0000000f", p, to);
    end
    n_vec++;
    if (bc !== 16) begin
      n_err++; $display("FAIL basic_busy_cycles: got %0d, want 16", bc);
    end
    n_vec++;
    if (dc !== 1) begin
      n_err++; $display("FAIL basic_done_width: got %0d, want 1", dc);
    end
    // product holds between operations
    repeat (3) @(negedge clk);
    n_vec++;
    if (product !== 32'h0000000F || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL basic_hold: product=%h busy=%b done=%b, want 0000000f/0/0",
                        product, busy, done);
    end
  endtask

  task automatic test_carry();
    int bc, dc; logic [31:0] p; bit to;
    run_op(16'hFFFF, 16'hFFFF, bc, dc, p, to);
    n_vec++;
    if (to || p !== 32'hFFFE0001) begin
      n_err++; $display("FAIL carry_ffff: product=%h timeout=%0d, want fffe0001", p, to);
    end
    run_op(16'h8000, 16'h8001, bc, dc, p, to);
    n_vec++;
    if (to || p !== 32'h40008000) begin
      n_err++; $display("FAIL carry_8000x8001: product=%h timeout=%0d, want 40008000", p, to);
    end
  endtask

  task automatic test_zero();
    int bc, dc; logic [31:0] p; bit to;
    run_op(16'h0000, 16'h1234, bc, dc, p, to);
    n_vec++;
    if (to || p !== 32'h0 || bc !== 16 || dc !== 1) begin
      n_err++; $display("FAIL zero_a: product=%h busy=%0d done=%0d, want 0/16/1", p, bc, dc);
    end
    run_op(16'h1234, 16'h0000, bc, dc, p, to);
    n_vec++;
    if (to || p !== 32'h0 || bc !== 16 || dc !== 1) begin
      n_err++; $display("FAIL zero_b: product=%h busy=%0d done=%0d, want 0/16/1", p, bc, dc);
    end
  endtask

  task automatic test_ignore_inputs();
    int dc; logic [31:0] p; bit seen_prod_change;
    dc = 0; p = 'x; seen_prod_change = 1'b0;
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done) begin dc++; p = product; end
      if (busy && product !== 32'h0) seen_prod_change = 1'b1;
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      start = (cyc == 5);
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (p !== 32'd63) begin
      n_err++; $display("FAIL ignore_inputs_product: got %h, want 0000003f", p);
    end
    n_vec++;
    if (dc !== 1) begin
      n_err++; $display("FAIL ignore_inputs_done_count: got %0d, want 1", dc);
    end
    n_vec++;
    if (seen_prod_change !== 1'b0 || product !== 32'd63) begin
      n_err++; $display("FAIL ignore_inputs_hold: product=%h changed_in_run=%b, want 0000003f/0",
                        product, seen_prod_change);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, cyc; bit bad_busy, to;
    d1 = -1; d2 = -1; bad_busy = 1'b0; to = 1'b1;
    @(negedge clk);
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(negedge clk);
    for (cyc = 0; cyc < 60; cyc++) begin
      if (busy === done) bad_busy = 1'b1;  // exactly one of busy/done while streaming
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc;
          n_vec++;
          if (product !== 32'd20000) begin
            n_err++; $display("FAIL b2b_first: product=%h, want 00004e20", product);
          end
          a = 16'h8000; b = 16'd2;
        end else begin
          d2 = cyc;
          n_vec++;
          if (product !== 32'h00010000) begin
            n_err++; $display("FAIL b2b_second: product=%h, want 00010000", product);
          end
          start = 1'b0;
          to = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (to || d2 - d1 !== 17) begin
      n_err++; $display("FAIL b2b_spacing: got %0d cycles timeout=%0d, want 17", d2 - d1, to);
    end
    n_vec++;
    if (bad_busy) begin
      n_err++; $display("FAIL b2b_busy_gap: busy low outside DONE, want busy low only in DONE");
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL b2b_idle: busy=%b done=%b state=%0d, want 0/0/0", busy, done, dbg_state);
    end
  endtask

  task automatic test_reset_mid_run();
    int bc, dc, early_done; logic [31:0] p; bit to;
    early_done = 0;
    @(negedge clk);
    a = 16'd5; b = 16'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) begin
      if (done) early_done++;
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_run: busy=%b done=%b product=%h, want 0/0/0",
                        busy, done, product);
    end
    // start presented while reset is held must not be accepted
    start = 1'b1;
    @(negedge clk);
    if (done) early_done++;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    if (done) early_done++;
    n_vec++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || early_done !== 0) begin
      n_err++; $display("FAIL reset_wins_start: busy=%b state=%0d done_pulses=%0d, want 0/0/0",
                        busy, dbg_state, early_done);
    end
    run_op(16'd5, 16'd6, bc, dc, p, to);
    n_vec++;
    if (to || p !== 32'd30 || bc !== 16 || dc !== 1) begin
      n_err++; $display("FAIL restart_after_reset: product=%h busy=%0d done=%0d, want 0000001e/16/1",
                        p, bc, dc);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
